// File: rtl/alu_operand_stage.sv
// ID/EX operand stage feeding the ALU: registers decoded operands under a
// valid/ready handshake, extends the immediate and applies EX forwarding.
module alu_operand_stage #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned RADDR = 5,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] rd1,
  input  logic [WIDTH-1:0] rd2,
  input  logic [15:0]      imm16,
  input  logic             sign_ext,
  input  logic             alu_src,
  input  logic [1:0]       alu_control_in,
  input  logic             reg_write_in,
  input  logic [RADDR-1:0] dst_in,
  input  logic             flush,
  input  logic [1:0]       fwd_a_sel,
  input  logic [1:0]       fwd_b_sel,
  input  logic [WIDTH-1:0] fwd_mem,
  input  logic [WIDTH-1:0] fwd_wb,
  output logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] B,
  output logic [1:0]       ALUControl,
  output logic [WIDTH-1:0] store_data,
  output logic             reg_write_out,
  output logic [RADDR-1:0] dst_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int unsigned EXT_W = WIDTH - 16;

  logic             r_valid;
  logic [WIDTH-1:0] r_rs;
  logic [WIDTH-1:0] r_rt;
  logic [WIDTH-1:0] r_imm;
  logic             r_alu_src;
  logic [1:0]       r_alu_control;
  logic             r_reg_write;
  logic [RADDR-1:0] r_dst;
  logic [CNT_W-1:0] r_stall_cnt;

  logic             w_capture;
  logic [WIDTH-1:0] w_imm_ext;
  logic [WIDTH-1:0] w_fwd_rs;
  logic [WIDTH-1:0] w_fwd_rt;

  assign in_ready  = !r_valid | out_ready;
  assign w_capture = in_valid & in_ready & !flush;
  assign w_imm_ext = sign_ext ? {{EXT_W{imm16[15]}}, imm16} : {{EXT_W{1'b0}}, imm16};

  // Flush wins over capture; data registers only change on capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid       <= 1'b0;
      r_rs          <= '0;
      r_rt          <= '0;
      r_imm         <= '0;
      r_alu_src     <= 1'b0;
      r_alu_control <= 2'b00;
      r_reg_write   <= 1'b0;
      r_dst         <= '0;
      r_stall_cnt   <= '0;
    end else begin
      if (flush) begin
        r_valid <= 1'b0;
      end else if (w_capture) begin
        r_valid       <= 1'b1;
        r_rs          <= rd1;
        r_rt          <= rd2;
        r_imm         <= w_imm_ext;
        r_alu_src     <= alu_src;
        r_alu_control <= alu_control_in;
        r_reg_write   <= reg_write_in;
        r_dst         <= dst_in;
      end else if (out_ready) begin
        r_valid <= 1'b0;
      end
      if (r_valid && !out_ready && (r_stall_cnt != {CNT_W{1'b1}})) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
    end
  end

  // Forwarding muxes on the registered operands; code 11 falls back to the register.
  always_comb begin
    w_fwd_rs = r_rs;
    w_fwd_rt = r_rt;
    case (fwd_a_sel)
      2'b01:   w_fwd_rs = fwd_mem;
      2'b10:   w_fwd_rs = fwd_wb;
      default: w_fwd_rs = r_rs;
    endcase
    case (fwd_b_sel)
      2'b01:   w_fwd_rt = fwd_mem;
      2'b10:   w_fwd_rt = fwd_wb;
      default: w_fwd_rt = r_rt;
    endcase
  end

  assign A             = w_fwd_rs;
  assign B             = r_alu_src ? r_imm : w_fwd_rt;
  assign store_data    = w_fwd_rt;
  assign ALUControl    = r_alu_control;
  assign reg_write_out = r_reg_write & r_valid;
  assign dst_out       = r_dst;
  assign out_valid     = r_valid;
  assign stall_cnt     = r_stall_cnt;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed bench for alu_operand_stage: handshake, immediates, stall,
// forwarding, flush and asynchronous reset.
module tb_alu_operand_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] rd1, rd2;
  logic [15:0] imm16;
  logic        sign_ext, alu_src;
  logic [1:0]  alu_control_in;
  logic        reg_write_in;
  logic [4:0]  dst_in;
  logic        flush;
  logic [1:0]  fwd_a_sel, fwd_b_sel;
  logic [31:0] fwd_mem, fwd_wb;
  logic [31:0] A, B, store_data;
  logic [1:0]  ALUControl;
  logic        reg_write_out;
  logic [4:0]  dst_out;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] stall_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  alu_operand_stage dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .rd1(rd1), .rd2(rd2), .imm16(imm16), .sign_ext(sign_ext), .alu_src(alu_src),
    .alu_control_in(alu_control_in), .reg_write_in(reg_write_in), .dst_in(dst_in),
    .flush(flush), .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
    .fwd_mem(fwd_mem), .fwd_wb(fwd_wb), .A(A), .B(B), .ALUControl(ALUControl),
    .store_data(store_data), .reg_write_out(reg_write_out), .dst_out(dst_out),
    .out_valid(out_valid), .out_ready(out_ready), .stall_cnt(stall_cnt)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; in_valid = 0; rd1 = 0; rd2 = 0; imm16 = 0; sign_ext = 0;
    alu_src = 0; alu_control_in = 0; reg_write_in = 0; dst_in = 0; flush = 0;
    fwd_a_sel = 0; fwd_b_sel = 0; fwd_mem = 0; fwd_wb = 0; out_ready = 1;
    tick(); tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b want=0", out_valid); end
    total++; if (A !== 32'h0 || B !== 32'h0 || store_data !== 32'h0) begin bad++; $display("FAIL reset_data got A=%h B=%h sd=%h want 0", A, B, store_data); end
    total++; if (ALUControl !== 2'b00 || reg_write_out !== 1'b0 || dst_out !== 5'd0) begin bad++; $display("FAIL reset_ctrl got ctl=%b rw=%b dst=%0d want 0", ALUControl, reg_write_out, dst_out); end
    total++; if (stall_cnt !== 16'd0 || in_ready !== 1'b1) begin bad++; $display("FAIL reset_cnt got cnt=%0d rdy=%b want 0/1", stall_cnt, in_ready); end
    rst_n = 1'b1;
  endtask

  task automatic test_add;
    in_valid = 1; rd1 = 32'd5; rd2 = 32'd3; alu_src = 0; alu_control_in = 2'b00;
    reg_write_in = 1; dst_in = 5'd7; out_ready = 1;
    tick();
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL add_valid got=%b want=1", out_valid); end
    total++; if (A !== 32'd5 || B !== 32'd3 || ALUControl !== 2'b00) begin bad++; $display("FAIL add_ops got A=%0d B=%0d ctl=%b want 5 3 00", A, B, ALUControl); end
    total++; if (A + B !== 32'd8) begin bad++; $display("FAIL add_sum got=%0d want=8", A + B); end
    total++; if (reg_write_out !== 1'b1 || dst_out !== 5'd7 || store_data !== 32'd3) begin bad++; $display("FAIL add_wb got rw=%b dst=%0d sd=%0d want 1 7 3", reg_write_out, dst_out, store_data); end
  endtask

  task automatic test_imm;
    imm16 = 16'hFFFB; sign_ext = 1; alu_src = 1; rd2 = 32'd44;
    tick();
    total++; if (B !== 32'hFFFFFFFB) begin bad++; $display("FAIL imm_sext got=%h want=fffffffb", B); end
    total++; if (store_data !== 32'd44) begin bad++; $display("FAIL imm_store got=%h want=0000002c", store_data); end
    sign_ext = 0;
    tick();
    total++; if (B !== 32'h0000FFFB) begin bad++; $display("FAIL imm_zext got=%h want=0000fffb", B); end
    alu_src = 0;
  endtask

  task automatic test_stall;
    rd1 = 32'h7FFFFFFF; out_ready = 1;
    tick();
    rd1 = 32'h00001234; out_ready = 0;
    #1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL stall_ready got=%b want=0", in_ready); end
    tick(); tick(); tick();
    total++; if (A !== 32'h7FFFFFFF || out_valid !== 1'b1) begin bad++; $display("FAIL stall_hold got A=%h v=%b want 7fffffff 1", A, out_valid); end
    total++; if (stall_cnt !== 16'd3) begin bad++; $display("FAIL stall_cnt got=%0d want=3", stall_cnt); end
    out_ready = 1;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL stall_release_ready got=%b want=1", in_ready); end
    tick();
    total++; if (A !== 32'h00001234 || out_valid !== 1'b1 || stall_cnt !== 16'd3) begin bad++; $display("FAIL stall_next got A=%h v=%b cnt=%0d want 00001234 1 3", A, out_valid, stall_cnt); end
  endtask

  task automatic test_forward;
    rd1 = 32'd10; rd2 = 32'd20; alu_control_in = 2'b10; alu_src = 0;
    tick();
    in_valid = 0; out_ready = 0;
    fwd_a_sel = 2'b01; fwd_mem = 32'h80000000; fwd_b_sel = 2'b10; fwd_wb = 32'd1;
    #1;
    total++; if (A !== 32'h80000000 || B !== 32'd1 || store_data !== 32'd1) begin bad++; $display("FAIL fwd_mem_wb got A=%h B=%h sd=%h want 80000000 1 1", A, B, store_data); end
    total++; if (ALUControl !== 2'b10) begin bad++; $display("FAIL fwd_ctl got=%b want=10", ALUControl); end
    fwd_a_sel = 2'b11; fwd_b_sel = 2'b11;
    #1;
    total++; if (A !== 32'd10 || B !== 32'd20) begin bad++; $display("FAIL fwd_code11 got A=%0d B=%0d want 10 20", A, B); end
    fwd_a_sel = 2'b10; fwd_b_sel = 2'b01;
    #1;
    total++; if (A !== 32'd1 || store_data !== 32'h80000000) begin bad++; $display("FAIL fwd_swap got A=%h sd=%h want 1 80000000", A, store_data); end
    fwd_a_sel = 0; fwd_b_sel = 0;
  endtask

  task automatic test_flush;
    // Previous instruction is stalled (out_ready=0) so its drop is visible.
    in_valid = 1; reg_write_in = 1; flush = 1; rd1 = 32'd99;
    tick();
    flush = 0; in_valid = 0;
    total++; if (out_valid !== 1'b0 || reg_write_out !== 1'b0) begin bad++; $display("FAIL flush got v=%b rw=%b want 0 0", out_valid, reg_write_out); end
    total++; if (A !== 32'd10 || stall_cnt !== 16'd4) begin bad++; $display("FAIL flush_hold got A=%0d cnt=%0d want 10 4", A, stall_cnt); end
    out_ready = 1;
  endtask

  task automatic test_back_to_back;
    in_valid = 1; rd1 = 32'd1; dst_in = 5'd3;
    tick();
    rd1 = 32'd2; dst_in = 5'd4;
    total++; if (A !== 32'd1 || dst_out !== 5'd3 || out_valid !== 1'b1) begin bad++; $display("FAIL b2b_first got A=%0d dst=%0d v=%b want 1 3 1", A, dst_out, out_valid); end
    tick();
    in_valid = 0;
    total++; if (A !== 32'd2 || dst_out !== 5'd4 || out_valid !== 1'b1) begin bad++; $display("FAIL b2b_second got A=%0d dst=%0d v=%b want 2 4 1", A, dst_out, out_valid); end
    tick();
    total++; if (out_valid !== 1'b0 || reg_write_out !== 1'b0 || A !== 32'd2) begin bad++; $display("FAIL b2b_drain got v=%b rw=%b A=%0d want 0 0 2", out_valid, reg_write_out, A); end
  endtask

  task automatic test_async_reset;
    in_valid = 1; rd1 = 32'd9; rd2 = 32'd4;
    tick();
    in_valid = 0; out_ready = 0;
    tick();
    total++; if (out_valid !== 1'b1 || stall_cnt !== 16'd5) begin bad++; $display("FAIL arst_pre got v=%b cnt=%0d want 1 5", out_valid, stall_cnt); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0 || A !== 32'd0 || B !== 32'd0 || stall_cnt !== 16'd0) begin bad++; $display("FAIL arst got v=%b A=%h B=%h cnt=%0d want all 0", out_valid, A, B, stall_cnt); end
    tick();
    rst_n = 1'b1; out_ready = 1;
  endtask

  initial begin
    test_reset();
    test_add();
    test_imm();
    test_stall();
    test_forward();
    test_flush();
    test_back_to_back();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_operand_stage.md
Name: alu_operand_stage

Overview:
ID/EX pipeline stage that sits directly upstream of the ALU and drives its A, B and ALUControl inputs. It registers decoded operands under a valid/ready handshake and performs immediate extension, ALUSrc selection and EX-stage forwarding. It supports stall (backpressure), flush (bubble insertion) and a saturating stall-cycle counter.

Parameters:
WIDTH, 32, datapath width; ALU operand width
RADDR, 5, register-file address width
CNT_W, 16, stall counter width

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  decode stage presents a valid instruction
in_ready  output  1  stage can accept this cycle
rd1  input  WIDTH  rs register-file data
rd2  input  WIDTH  rt register-file data
imm16  input  16  instruction immediate
sign_ext  input  1  1 = sign-extend imm16, 0 = zero-extend
alu_src  input  1  1 = B takes extended immediate, 0 = B takes forwarded rt
alu_control_in  input  2  00 ADD, 01 XOR, 10 SUB, 11 SLT
reg_write_in  input  1  instruction writes a register
dst_in  input  RADDR  destination register
flush  input  1  discard held and incoming instruction
fwd_a_sel  input  2  00 reg, 01 MEM result, 10 WB result, 11 reg
fwd_b_sel  input  2  same encoding, applies to rt path
fwd_mem  input  WIDTH  MEM-stage forwarded value
fwd_wb  input  WIDTH  WB-stage forwarded value
A  output  WIDTH  to ALU A
B  output  WIDTH  to ALU B
ALUControl  output  2  to ALU ALUControl
store_data  output  WIDTH  forwarded rt (for SW), independent of alu_src
reg_write_out  output  1  registered reg_write_in, gated by out_valid
dst_out  output  RADDR  registered destination
out_valid  output  1  stage holds a valid instruction
out_ready  input  1  EX stage consumes this cycle
stall_cnt  output  CNT_W  cycles with out_valid=1 and out_ready=0, saturating

Behaviour:
- Reset (rst_n=0, async): out_valid=0, all holding registers 0, stall_cnt=0, so A=B=0, ALUControl=00, store_data=0, reg_write_out=0, dst_out=0.
- in_ready = !out_valid | out_ready (combinational; no input-to-output comb path other than out_ready).
- capture = in_valid & in_ready & !flush. On capture, register rd1, rd2, extended immediate, alu_src, alu_control_in, reg_write_in, dst_in; out_valid<=1. Latency 1 cycle.
- No capture and out_ready=1: out_valid<=0, data registers hold.
- out_valid=1, out_ready=0: all registers hold (stall).
- flush=1: out_valid<=0 next cycle regardless of in_valid and out_ready; incoming instruction dropped; flush beats capture.
- Immediate extension at capture: sign_ext=1 -> {16{imm16[15]},imm16}; else {16'h0,imm16}.
- Forwarding is combinational on the registered values: A = mux(fwd_a_sel, rs_q, fwd_mem, fwd_wb); code 11 selects the register value. fwd_rt is formed the same way from rt_q with fwd_b_sel.
- B = alu_src_q ? imm_q : fwd_rt. store_data = fwd_rt always.
- reg_write_out = reg_write_q & out_valid, so a bubble never writes.
- stall_cnt increments when out_valid & !out_ready and saturates at 2^CNT_W-1. It is cleared only by reset.
- Reset asserted mid-stall clears out_valid immediately; the held instruction is lost.

Test Plan:
- Reset, then in_valid=1, rd1=5, rd2=3, alu_src=0, ctrl=00, out_ready=1 -> next cycle out_valid=1, A=5, B=3, ALUControl=00; ALU result 8.
- imm16=16'hFFFB, sign_ext=1, alu_src=1 -> B=32'hFFFFFFFB. Repeat with sign_ext=0 -> B=32'h0000FFFB.
- Capture rd1=32'h7FFFFFFF, then hold out_ready=0 for 3 cycles while in_valid=1 with new data -> in_ready=0, A stays 32'h7FFFFFFF, stall_cnt=3. Release -> new instruction captured the following cycle.
- Holding valid SUB with rd1=10, fwd_a_sel=01, fwd_mem=32'h80000000, fwd_b_sel=10, fwd_wb=1, alu_src=0 -> A=32'h80000000, B=1, store_data=1.
- flush=1 in the same cycle as in_valid=1, reg_write_in=1 -> next cycle out_valid=0, reg_write_out=0. The previous instruction is also dropped.
- Drive rst_n low asynchronously between clock edges while out_valid=1 -> out_valid, A, B and stall_cnt read 0 before the next clk edge.
